// File: rtl/w5300_socket_tx_engine_if.sv
// Register-access bus between the socket TX engine and w5300_interface.
// The engine is the master: it raises ctrl_req and the interface answers with a one-cycle ctrl_op_state.
interface w5300_socket_tx_engine_if;
    logic        ctrl_req;
    logic [10:0] ctrl_addr;
    logic [15:0] ctrl_wr_data;
    logic [15:0] ctrl_rd_data;
    logic        ctrl_op_state;

    modport master (
        output ctrl_req, ctrl_addr, ctrl_wr_data,
        input  ctrl_rd_data, ctrl_op_state
    );

    modport slave (
        input  ctrl_req, ctrl_addr, ctrl_wr_data,
        output ctrl_rd_data, ctrl_op_state
    );
endinterface

// File: rtl/w5300_socket_tx_engine.sv
// W5300 socket transmit engine: free-space check, FIFO fill, WRSR write and SEND.
// The optional W5300_TX_SENDOK_WAIT_EN macro adds SENDOK polling and clearing after SEND.
module w5300_socket_tx_engine #(
    parameter int SOCKET         = 0,
    parameter int BUF_AW         = 16,
    parameter int TX_MAX_BYTES   = 8192,
    parameter int TIMEOUT_CYCLES = 6000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_req,
    input  logic [16:0]       tx_len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [BUF_AW-1:0] buf_addr,
    output logic              buf_rd,
    input  logic [15:0]       buf_data,
    w5300_socket_tx_engine_if.master ctrl
);
    localparam logic [9:0] BASE  = 10'(10'h200 + SOCKET * 10'h040);
    localparam int         TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_RD_FSR0  = 4'd1;
    localparam logic [3:0] ST_RD_FSR1  = 4'd2;
    localparam logic [3:0] ST_CHK_FSR  = 4'd3;
    localparam logic [3:0] ST_FETCH    = 4'd4;
    localparam logic [3:0] ST_WR_FIFO  = 4'd5;
    localparam logic [3:0] ST_WR_WRSR0 = 4'd6;
    localparam logic [3:0] ST_WR_WRSR1 = 4'd7;
    localparam logic [3:0] ST_WR_CMD   = 4'd8;
`ifdef W5300_TX_SENDOK_WAIT_EN
    localparam logic [3:0] ST_POLL_IR  = 4'd9;
    localparam logic [3:0] ST_CLR_IR   = 4'd10;
`endif
    localparam logic [3:0] ST_DONE     = 4'd11;
    localparam logic [3:0] ST_ERROR    = 4'd12;

    logic [3:0]       state;
    logic [16:0]      len_q;
    logic [16:0]      free_q;
    logic [16:0]      word_idx;
    logic [16:0]      words;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_exp;

    logic             acc_en;
    logic             acc_wr;
    logic [9:0]       acc_off;
    logic [15:0]      acc_data;
    logic             acc_done;

    assign words    = (len_q + 17'd1) >> 1;
    assign tmo_exp  = tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1);
    assign busy     = state != ST_IDLE;
    assign done     = state == ST_DONE;
    assign error    = state == ST_ERROR;
    assign buf_rd   = state == ST_FETCH;
    assign buf_addr = BUF_AW'(word_idx);

    // Which register each bus state touches; buf_data is valid on entry to WR_FIFO.
    always_comb begin
        acc_en   = 1'b0;
        acc_wr   = 1'b0;
        acc_off  = 10'h000;
        acc_data = 16'h0000;
        case (state)
            ST_RD_FSR0:  begin acc_en = 1'b1; acc_off = 10'h024; end
            ST_RD_FSR1:  begin acc_en = 1'b1; acc_off = 10'h026; end
            ST_WR_FIFO:  begin acc_en = 1'b1; acc_wr = 1'b1; acc_off = 10'h02E; acc_data = buf_data; end
            ST_WR_WRSR0: begin acc_en = 1'b1; acc_wr = 1'b1; acc_off = 10'h020; acc_data = {15'b0, len_q[16]}; end
            ST_WR_WRSR1: begin acc_en = 1'b1; acc_wr = 1'b1; acc_off = 10'h022; acc_data = len_q[15:0]; end
            ST_WR_CMD:   begin acc_en = 1'b1; acc_wr = 1'b1; acc_off = 10'h002; acc_data = 16'h0020; end
`ifdef W5300_TX_SENDOK_WAIT_EN
            ST_POLL_IR:  begin acc_en = 1'b1; acc_off = 10'h006; end
            ST_CLR_IR:   begin acc_en = 1'b1; acc_wr = 1'b1; acc_off = 10'h006; acc_data = 16'h0010; end
`endif
            default: ;
        endcase
    end

    assign acc_done = acc_en && ctrl.ctrl_req && ctrl.ctrl_op_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            len_q             <= '0;
            free_q            <= '0;
            word_idx          <= '0;
            tmo_cnt           <= '0;
            ctrl.ctrl_req     <= 1'b0;
            ctrl.ctrl_addr    <= '0;
            ctrl.ctrl_wr_data <= '0;
        end else begin
            if (!tmo_exp)
                tmo_cnt <= tmo_cnt + 1'b1;

            // Issue when idle on the bus; drop the request the cycle after completion.
            if (acc_en && !ctrl.ctrl_req) begin
                ctrl.ctrl_req     <= 1'b1;
                ctrl.ctrl_addr    <= {acc_wr, BASE + acc_off};
                ctrl.ctrl_wr_data <= acc_data;
            end else if (acc_done) begin
                ctrl.ctrl_req <= 1'b0;
            end

            case (state)
                ST_IDLE: if (tx_req) begin
                    len_q    <= tx_len;
                    word_idx <= '0;
                    if (tx_len == 17'd0)
                        state <= ST_DONE;
                    else if (tx_len > 17'(TX_MAX_BYTES))
                        state <= ST_ERROR;
                    else begin
                        state   <= ST_RD_FSR0;
                        tmo_cnt <= '0;
                    end
                end
                ST_RD_FSR0: if (acc_done) begin
                    free_q[16] <= ctrl.ctrl_rd_data[0];
                    state      <= ST_RD_FSR1;
                end
                ST_RD_FSR1: if (acc_done) begin
                    free_q[15:0] <= ctrl.ctrl_rd_data;
                    state        <= ST_CHK_FSR;
                end
                ST_CHK_FSR:
                    if (free_q >= len_q) state <= ST_FETCH;
                    else if (tmo_exp)    state <= ST_ERROR;
                    else                 state <= ST_RD_FSR0;
                ST_FETCH: state <= ST_WR_FIFO;
                ST_WR_FIFO: if (acc_done) begin
                    word_idx <= word_idx + 17'd1;
                    state    <= (word_idx + 17'd1 == words) ? ST_WR_WRSR0 : ST_FETCH;
                end
                ST_WR_WRSR0: if (acc_done) state <= ST_WR_WRSR1;
                ST_WR_WRSR1: if (acc_done) state <= ST_WR_CMD;
`ifdef W5300_TX_SENDOK_WAIT_EN
                ST_WR_CMD: if (acc_done) begin
                    state   <= ST_POLL_IR;
                    tmo_cnt <= '0;
                end
                ST_POLL_IR: if (acc_done) begin
                    if (ctrl.ctrl_rd_data[4]) state <= ST_CLR_IR;
                    else if (tmo_exp)         state <= ST_ERROR;
                end
                ST_CLR_IR: if (acc_done) state <= ST_DONE;
`else
                ST_WR_CMD: if (acc_done) state <= ST_DONE;
`endif
                ST_DONE:  state <= ST_IDLE;
                ST_ERROR: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_w5300_socket_tx_engine.sv
// Directed bench for w5300_socket_tx_engine with a latency-2 register-bus responder and a small TX buffer.
module tb_w5300_socket_tx_engine;
    localparam int TMO = 6000;

    typedef struct packed {
        logic        w;
        logic [9:0]  a;
        logic [15:0] d;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_req = 1'b0;
    logic [16:0] tx_len = '0;
    logic        busy, done, error;
    logic [15:0] buf_addr;
    logic        buf_rd;
    logic [15:0] buf_data = '0;

    logic [15:0] mem [0:15];
    logic [15:0] fsr_hi = 16'h0000;
    logic [15:0] fsr_lo = 16'h2000;
    logic [15:0] ir_val = 16'h0010;
    acc_t        log_q [$];
    acc_t        exp_q [$];
    bit          req_seen;

    int checks = 0;
    int errors = 0;

    w5300_socket_tx_engine_if bus ();

    w5300_socket_tx_engine #(
        .SOCKET(0), .BUF_AW(16), .TX_MAX_BYTES(8192), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .tx_len(tx_len),
        .busy(busy), .done(done), .error(error),
        .buf_addr(buf_addr), .buf_rd(buf_rd), .buf_data(buf_data),
        .ctrl(bus.master)
    );

    always #5 clk = ~clk;

    // Bus responder: completes each request two negedges after it is seen and logs it.
    initial begin
        int cnt;
        cnt = 0;
        bus.ctrl_op_state = 1'b0;
        bus.ctrl_rd_data  = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.ctrl_op_state = 1'b0;
                cnt = 0;
            end else if (bus.ctrl_op_state) begin
                bus.ctrl_op_state = 1'b0;
                cnt = 0;
            end else if (bus.ctrl_req) begin
                req_seen = 1'b1;
                cnt++;
                if (cnt == 2) begin
                    bus.ctrl_op_state = 1'b1;
                    case (bus.ctrl_addr[9:0])
                        10'h224: bus.ctrl_rd_data = fsr_hi;
                        10'h226: bus.ctrl_rd_data = fsr_lo;
                        10'h206: bus.ctrl_rd_data = ir_val;
                        default: bus.ctrl_rd_data = 16'hDEAD;
                    endcase
                    log_q.push_back('{w: bus.ctrl_addr[10], a: bus.ctrl_addr[9:0],
                                      d: bus.ctrl_addr[10] ? bus.ctrl_wr_data : 16'h0000});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (buf_rd) buf_data = mem[buf_addr[3:0]];
        end
    end

    function automatic void exp_fsr();
        exp_q.push_back('{w: 1'b0, a: 10'h224, d: 16'h0000});
        exp_q.push_back('{w: 1'b0, a: 10'h226, d: 16'h0000});
    endfunction

    function automatic void exp_tail(input logic [16:0] len);
        exp_q.push_back('{w: 1'b1, a: 10'h220, d: {15'b0, len[16]}});
        exp_q.push_back('{w: 1'b1, a: 10'h222, d: len[15:0]});
        exp_q.push_back('{w: 1'b1, a: 10'h202, d: 16'h0020});
`ifdef W5300_TX_SENDOK_WAIT_EN
        exp_q.push_back('{w: 1'b0, a: 10'h206, d: 16'h0000});
        exp_q.push_back('{w: 1'b1, a: 10'h206, d: 16'h0010});
`endif
    endfunction

    task automatic start_tx(input logic [16:0] len);
        log_q.delete();
        exp_q.delete();
        req_seen = 1'b0;
        @(negedge clk);
        tx_req = 1'b1;
        tx_len = len;
        @(negedge clk);
        tx_req = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cyc);
        cyc = 1;
        while (!done && !error && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, buf_rd, bus.ctrl_req} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags actual=%b required=00000", {busy, done, error, buf_rd, bus.ctrl_req});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.ctrl_addr !== 11'h0 || bus.ctrl_wr_data !== 16'h0 || buf_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus actual=%h/%h/%h required=0/0/0", bus.ctrl_addr, bus.ctrl_wr_data, buf_addr);
        end
        checks++;
        if ({busy, done, error, bus.ctrl_req} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle actual=%b required=0000", {busy, done, error, bus.ctrl_req});
        end
    endtask

    // len=4 with a second tx_req (len=2) while busy, which must be ignored.
    task automatic test_basic();
        int cyc, dones;
        mem[0] = 16'hA1B2; mem[1] = 16'hC3D4;
        fsr_hi = 16'h0000; fsr_lo = 16'h2000; ir_val = 16'h0010;
        start_tx(17'd4);
        repeat (4) @(negedge clk);
        tx_req = 1'b1; tx_len = 17'd2;
        @(negedge clk);
        tx_req = 1'b0;
        wait_end(400, cyc);
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL basic_done actual=%b%b required=10 cycles=%0d", done, error, cyc);
        end
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_single_pulse actual extra_dones=%0d busy=%b required=0/0", dones, busy);
        end
        exp_fsr();
        exp_q.push_back('{w: 1'b1, a: 10'h22E, d: 16'hA1B2});
        exp_q.push_back('{w: 1'b1, a: 10'h22E, d: 16'hC3D4});
        exp_tail(17'd4);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count actual=%0d required=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_seq[%0d] actual=%b %h %h required=%b %h %h", i,
                         log_q[i].w, log_q[i].a, log_q[i].d, exp_q[i].w, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_odd_len();
        int cyc;
        mem[0] = 16'h1122; mem[1] = 16'h3344; mem[2] = 16'h5566;
        start_tx(17'd5);
        wait_end(400, cyc);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL odd_done actual=%b required=1", done);
        end
        exp_fsr();
        exp_q.push_back('{w: 1'b1, a: 10'h22E, d: 16'h1122});
        exp_q.push_back('{w: 1'b1, a: 10'h22E, d: 16'h3344});
        exp_q.push_back('{w: 1'b1, a: 10'h22E, d: 16'h5566});
        exp_tail(17'd5);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL odd_count actual=%0d required=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL odd_seq[%0d] actual=%b %h %h required=%b %h %h", i,
                         log_q[i].w, log_q[i].a, log_q[i].d, exp_q[i].w, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_zero_len();
        int cyc;
        start_tx(17'd0);
        wait_end(10, cyc);
        checks++;
        if (done !== 1'b1 || cyc > 2) begin
            errors++;
            $display("FAIL zero_done actual done=%b cycles=%0d required done=1 cycles<=2", done, cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (req_seen || log_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_bus actual req_seen=%b accesses=%0d busy=%b required 0/0/0",
                     req_seen, log_q.size(), busy);
        end
    endtask

    task automatic test_reject();
        int cyc;
        start_tx(17'd8193);
        wait_end(10, cyc);
        checks++;
        if (error !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reject_error actual err=%b done=%b required 1/0", error, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (req_seen || log_q.size() != 0) begin
            errors++;
            $display("FAIL reject_no_bus actual req_seen=%b accesses=%0d required 0/0", req_seen, log_q.size());
        end
    endtask

    task automatic test_fsr_timeout();
        int cyc;
        bit any_wr;
        fsr_hi = 16'h0000; fsr_lo = 16'h0002;
        start_tx(17'd4);
        wait_end(TMO + 200, cyc);
        checks++;
        if (error !== 1'b1 || cyc < TMO || cyc > TMO + 20) begin
            errors++;
            $display("FAIL timeout_error actual err=%b cycles=%0d required err=1 cycles in [%0d,%0d]",
                     error, cyc, TMO, TMO + 20);
        end
        repeat (3) @(negedge clk);
        any_wr = 1'b0;
        foreach (log_q[i]) if (log_q[i].w || (log_q[i].a != 10'h224 && log_q[i].a != 10'h226)) any_wr = 1'b1;
        checks++;
        if (any_wr || log_q.size() < 4 || bus.ctrl_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_reads_only actual other=%b accesses=%0d req=%b required 0/>=4/0",
                     any_wr, log_q.size(), bus.ctrl_req);
        end
        fsr_lo = 16'h2000;
    endtask

    task automatic test_reset_mid();
        int n, cyc;
        mem[0] = 16'hA1B2; mem[1] = 16'hC3D4;
        start_tx(17'd4);
        n = 0;
        while (!(log_q.size() == 3 && bus.ctrl_req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL midrst_reach actual accesses=%0d required 3 with request pending", log_q.size());
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, buf_rd, bus.ctrl_req} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_async actual=%b required=00000", {busy, done, error, buf_rd, bus.ctrl_req});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_tx(17'd4);
        wait_end(400, cyc);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL midrst_rerun_done actual=%b required=1", done);
        end
        exp_fsr();
        exp_q.push_back('{w: 1'b1, a: 10'h22E, d: 16'hA1B2});
        exp_q.push_back('{w: 1'b1, a: 10'h22E, d: 16'hC3D4});
        exp_tail(17'd4);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midrst_count actual=%0d required=%0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_seq[%0d] actual=%b %h %h required=%b %h %h", i,
                         log_q[i].w, log_q[i].a, log_q[i].d, exp_q[i].w, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        test_reset();
        test_basic();
        test_odd_len();
        test_zero_len();
        test_reject();
        test_fsr_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
